// File: rtl/inject_scheduler.sv
// Shares the router's six local injection ports among NUM_REQ requesters.
// Each port has a round-robin arbiter that stays locked to its winner until the tail flit.
module inject_scheduler #(
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TAIL_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ*3-1:0]  req_dir,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [6*FLIT_W-1:0]   inject_flit,
  output logic [5:0]            inject_valid,
  input  logic [5:0]            inject_avail,
  output logic [NUM_REQ-1:0]    bad_dir_err
);

  localparam int unsigned NumDir = 6;
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q [NumDir];
  state_e            state_d [NumDir];
  logic [IdxW-1:0]   owner_q [NumDir];
  logic [IdxW-1:0]   owner_d [NumDir];
  logic [IdxW-1:0]   ptr_q   [NumDir];
  logic [IdxW-1:0]   ptr_d   [NumDir];
  logic [6*FLIT_W-1:0] flit_q, flit_d;
  logic [5:0]          ivalid_q, ivalid_d;
  logic [NUM_REQ-1:0]  bad_q, bad_d;
  logic [NUM_REQ-1:0]  busy;
  logic [NUM_REQ-1:0]  ready_c;

  // A requester owned by any port is invisible to every other arbiter.
  always_comb begin
    busy = '0;
    for (int d = 0; d < NumDir; d++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (state_q[d] == StLocked && owner_q[d] == IdxW'(r)) busy[r] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [FLIT_W-1:0] cur;
    logic              found;
    int unsigned       idx;
    cur      = '0;
    found    = 1'b0;
    idx      = 0;
    ready_c  = '0;
    ivalid_d = '0;
    flit_d   = flit_q;
    bad_d    = '0;
    for (int d = 0; d < NumDir; d++) begin
      state_d[d] = state_q[d];
      owner_d[d] = owner_q[d];
      ptr_d[d]   = ptr_q[d];
    end

    for (int r = 0; r < NUM_REQ; r++) begin
      bad_d[r] = req_valid[r] && !busy[r] && (req_dir[r*3 +: 3] >= 3'd6);
    end

    for (int d = 0; d < NumDir; d++) begin
      if (state_q[d] == StLocked) begin
        if (req_valid[owner_q[d]] && inject_avail[d]) begin
          ready_c[owner_q[d]]         = 1'b1;
          cur                         = req_flit[owner_q[d]*FLIT_W +: FLIT_W];
          ivalid_d[d]                 = 1'b1;
          flit_d[d*FLIT_W +: FLIT_W]  = cur;
          if (cur[TAIL_BIT]) begin
            state_d[d] = StIdle;
            ptr_d[d]   = (owner_q[d] == IdxW'(NUM_REQ - 1)) ? '0 : owner_q[d] + 1'b1;
          end
        end
      end else begin
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          idx = int'(ptr_q[d]) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!found && req_valid[idx] && !busy[idx] && req_dir[idx*3 +: 3] == 3'(d)) begin
            found      = 1'b1;
            owner_d[d] = IdxW'(idx);
            state_d[d] = StLocked;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NumDir; d++) begin
        state_q[d] <= StIdle;
        owner_q[d] <= '0;
        ptr_q[d]   <= '0;
      end
      flit_q   <= '0;
      ivalid_q <= '0;
      bad_q    <= '0;
    end else begin
      for (int d = 0; d < NumDir; d++) begin
        state_q[d] <= state_d[d];
        owner_q[d] <= owner_d[d];
        ptr_q[d]   <= ptr_d[d];
      end
      flit_q   <= flit_d;
      ivalid_q <= ivalid_d;
      bad_q    <= bad_d;
    end
  end

  // Ready is combinational off the lock state, so it is forced low while reset is held.
  assign req_ready    = rst ? '0 : ready_c;
  assign inject_flit  = flit_q;
  assign inject_valid = ivalid_q;
  assign bad_dir_err  = bad_q;

endmodule

// File: tb/tb_inject_scheduler.sv
// Directed, table-driven bench for inject_scheduler (NUM_REQ=4, 8-bit flits, tail on bit 0).
module tb_inject_scheduler;

  localparam int unsigned FW = 8;
  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*FW-1:0] req_flit;
  logic [NR*3-1:0]  req_dir;
  logic [NR-1:0] req_ready;
  logic [6*FW-1:0] inject_flit;
  logic [5:0]    inject_valid;
  logic [5:0]    inject_avail;
  logic [NR-1:0] bad_dir_err;

  int checks = 0;
  int errors = 0;

  inject_scheduler #(.FLIT_W(FW), .NUM_REQ(NR), .TAIL_BIT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_flit     (req_flit),
    .req_dir      (req_dir),
    .req_ready    (req_ready),
    .inject_flit  (inject_flit),
    .inject_valid (inject_valid),
    .inject_avail (inject_avail),
    .bad_dir_err  (bad_dir_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [11:0] dir;
    logic [31:0] flit;
    logic [5:0]  avail;
    logic [3:0]  ready;
    logic [5:0]  ivalid;
    logic [47:0] iflit;
    logic [3:0]  bad;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [11:0] dir,
                     input logic [31:0] flit, input logic [5:0] avail, input logic [3:0] ready,
                     input logic [5:0] ivalid, input logic [47:0] iflit, input logic [3:0] bad);
    vec_t e;
    e.rst = r; e.v = v; e.dir = dir; e.flit = flit; e.avail = avail;
    e.ready = ready; e.ivalid = ivalid; e.iflit = iflit; e.bad = bad;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  localparam logic [5:0] A = 6'h3F;

  initial begin
    // 1: req0 three-flit packet on dir 1
    add(0, 4'h1, 12'h001, 32'h10, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h1, 12'h001, 32'h10, A, 4'h1, 6'h00, 48'h0, 4'h0);
    add(0, 4'h1, 12'h001, 32'h20, A, 4'h1, 6'h02, 48'h0000_0000_1000, 4'h0);
    add(0, 4'h1, 12'h001, 32'h31, A, 4'h1, 6'h02, 48'h0000_0000_2000, 4'h0);
    add(0, 4'h0, 12'h000, 32'h00, A, 4'h0, 6'h02, 48'h0000_0000_3100, 4'h0);
    add(0, 4'h0, 12'h000, 32'h00, A, 4'h0, 6'h00, 48'h0, 4'h0);
    // 5: req0 with dir 7 for two cycles
    add(0, 4'h1, 12'h007, 32'h00, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h1, 12'h007, 32'h00, A, 4'h0, 6'h00, 48'h0, 4'h1);
    add(0, 4'h0, 12'h000, 32'h00, A, 4'h0, 6'h00, 48'h0, 4'h1);
    add(0, 4'h0, 12'h000, 32'h00, A, 4'h0, 6'h00, 48'h0, 4'h0);
    // 2: req0..2 single-flit packets on dir 0, round robin with bubbles
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h1, 6'h00, 48'h0, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h0, 6'h01, 48'h01, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h2, 6'h00, 48'h0, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h0, 6'h01, 48'h03, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h4, 6'h00, 48'h0, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h0, 6'h01, 48'h05, 4'h0);
    add(0, 4'h7, 12'h000, 32'h0005_0301, A, 4'h1, 6'h00, 48'h0, 4'h0);
    add(0, 4'h0, 12'h000, 32'h0005_0301, A, 4'h0, 6'h01, 48'h01, 4'h0);
    // ptr[0] is now 1: with req0 and req1 competing, req1 wins
    add(0, 4'h3, 12'h000, 32'h0005_0301, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h3, 12'h000, 32'h0005_0301, A, 4'h2, 6'h00, 48'h0, 4'h0);
    add(0, 4'h0, 12'h000, 32'h0005_0301, A, 4'h0, 6'h01, 48'h03, 4'h0);
    // 3: req1 on dir 3 with avail[3] toggling 1,0,0,1
    add(0, 4'h2, 12'h018, 32'h4000, A,     4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h2, 12'h018, 32'h4000, A,     4'h2, 6'h00, 48'h0, 4'h0);
    add(0, 4'h2, 12'h018, 32'h5000, 6'h37, 4'h0, 6'h08, 48'h0000_4000_0000, 4'h0);
    add(0, 4'h2, 12'h018, 32'h5000, 6'h37, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h2, 12'h018, 32'h5000, A,     4'h2, 6'h00, 48'h0, 4'h0);
    add(0, 4'h2, 12'h018, 32'h6100, A,     4'h2, 6'h08, 48'h0000_5000_0000, 4'h0);
    add(0, 4'h0, 12'h018, 32'h0000, A,     4'h0, 6'h08, 48'h0000_6100_0000, 4'h0);
    // 4: req2 locked on dir 4 switches req_dir to 5 while req3 takes dir 5
    add(0, 4'h4, 12'h100, 32'h0080_0000, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'hC, 12'hB40, 32'h9180_0000, A, 4'h4, 6'h00, 48'h0, 4'h0);
    add(0, 4'hC, 12'hB40, 32'h91A0_0000, A, 4'hC, 6'h10, 48'h0080_0000_0000, 4'h0);
    add(0, 4'h4, 12'hB40, 32'h00B1_0000, A, 4'h4, 6'h30, 48'h91A0_0000_0000, 4'h0);
    add(0, 4'h4, 12'h140, 32'h00C1_0000, A, 4'h0, 6'h10, 48'h00B1_0000_0000, 4'h0);
    add(0, 4'h4, 12'h140, 32'h00C1_0000, A, 4'h4, 6'h00, 48'h0, 4'h0);
    add(0, 4'h0, 12'h000, 32'h0000_0000, A, 4'h0, 6'h20, 48'hC100_0000_0000, 4'h0);
    // 6: reset while dirs 0 and 2 are locked; afterwards ptr[0] restarts at 0
    add(0, 4'h3, 12'h010, 32'h0000_2010, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h3, 12'h010, 32'h0000_2010, A, 4'h3, 6'h00, 48'h0, 4'h0);
    add(1, 4'h3, 12'h010, 32'h0000_2010, A, 4'h0, 6'h05, 48'h0000_0020_0010, 4'h0);
    add(0, 4'h6, 12'h000, 32'h0005_0300, A, 4'h0, 6'h00, 48'h0, 4'h0);
    add(0, 4'h6, 12'h000, 32'h0005_0300, A, 4'h2, 6'h00, 48'h0, 4'h0);
    add(0, 4'h0, 12'h000, 32'h0000_0000, A, 4'h0, 6'h01, 48'h03, 4'h0);
    add(0, 4'h0, 12'h000, 32'h0000_0000, A, 4'h0, 6'h00, 48'h0, 4'h0);

    rst = 1'b1; req_valid = '0; req_flit = '0; req_dir = '0; inject_avail = A;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 48'(req_ready), 48'h0);
    chk("reset ivalid", 48'(inject_valid), 48'h0);
    chk("reset iflit", inject_flit, 48'h0);
    chk("reset bad", 48'(bad_dir_err), 48'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; req_valid = tbl[i].v; req_dir = tbl[i].dir;
      req_flit = tbl[i].flit; inject_avail = tbl[i].avail;
      #3;
      chk($sformatf("row%0d ready", i), 48'(req_ready), 48'(tbl[i].ready));
      chk($sformatf("row%0d ivalid", i), 48'(inject_valid), 48'(tbl[i].ivalid));
      chk($sformatf("row%0d bad", i), 48'(bad_dir_err), 48'(tbl[i].bad));
      for (int d = 0; d < 6; d++) begin
        if (tbl[i].ivalid[d])
          chk($sformatf("row%0d flit%0d", i, d), 48'(inject_flit[d*FW +: FW]),
              48'(tbl[i].iflit[d*FW +: FW]));
      end
    end

    // Owner drops valid mid-packet: the port stays locked and req1 is never served.
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'h1; req_dir = '0; req_flit = 32'h0000_0310; inject_avail = A;
    @(posedge clk); #1;
    #3 chk("drop lock ready", 48'(req_ready), 48'h1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 4'h2;
      #3 chk($sformatf("drop stall%0d ready", c), 48'(req_ready), 48'h0);
    end
    @(posedge clk); #1;
    req_valid = 4'h3; req_flit = 32'h0000_0311;
    #3 chk("drop resume ready", 48'(req_ready), 48'h1);
    @(posedge clk); #1;
    req_valid = 4'h0;
    #3 chk("drop resume ivalid", 48'(inject_valid), 48'h01);
    chk("drop resume flit", 48'(inject_flit[FW-1:0]), 48'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
